// File: rtl/mips_pkg.sv
// Shared widths and the writeback request record used by the arbiter and its queue.
// Entries carry a live bit so a younger ALU write can cancel a pending MDU write.
package mips_pkg;
    localparam int REG_W         = 5;
    localparam int DATA_W        = 32;
    localparam int WB_FIFO_DEPTH = 4;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the execute/decode stages and the writeback arbiter.
// master = pipeline side driving requests and read addresses, slave = arbiter.
interface wb_arbiter_if;
    import mips_pkg::*;

    logic              alu_valid;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_W-1:0]  mdu_reg;
    logic [DATA_W-1:0] mdu_data;
    logic              RegWrite;
    logic [REG_W-1:0]  WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [REG_W-1:0]  ReadReg1;
    logic [REG_W-1:0]  ReadReg2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic              busy;

    modport master (
        output alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data, ReadReg1, ReadReg2,
        input  mdu_ready, RegWrite, WriteReg, WriteData, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data, ReadReg1, ReadReg2,
        output mdu_ready, RegWrite, WriteReg, WriteData, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// MDU writeback queue: circular storage, pointers, occupancy count and live-bit kill.
// One-cycle push-to-pop; the caller gates push on free space and pop on occupancy.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pushEn,
    input  wb_req_t                    pushEntry,
    input  logic                       popEn,
    input  logic                       killEn,
    input  logic [REG_W-1:0]           killReg,
    output wb_req_t                    entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   headPtr,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] tailPtr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].live <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (killEn && (entries[i].wreg == killReg)) entries[i].live <= 1'b0;
            end
            // An entry arriving alongside an ALU write to the same register is dead on arrival.
            if (pushEn) begin
                entries[tailPtr].live <= pushEntry.live && !(killEn && (killReg == pushEntry.wreg));
                entries[tailPtr].wreg <= pushEntry.wreg;
                entries[tailPtr].data <= pushEntry.data;
                tailPtr               <= tailPtr + PTR_W'(1);
            end
            if (popEn) headPtr <= headPtr + PTR_W'(1);
            case ({pushEn, popEn})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU writes take priority, MDU results queue behind them.
// One-cycle ALU latency, two-cycle minimum MDU latency; mdu_ready drops only when the queue is full.
module wb_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_req_t           entries [DEPTH];
    wb_req_t           headEntry;
    wb_req_t           pushEntry;
    logic [PTR_W-1:0]  headPtr;
    logic [CNT_W-1:0]  count;
    logic              aluWrite;
    logic              pushEn;
    logic              popEn;
    logic [REG_W-1:0]  rdAddr [2];
    logic [1:0]        hit;
    logic [DATA_W-1:0] fwd [2];

    assign aluWrite      = bus.alu_valid && (bus.alu_reg != '0);
    assign bus.mdu_ready = reset && (count < FULL_CNT);
    // Writes to r0 are handshaken but never stored.
    assign pushEn        = bus.mdu_valid && bus.mdu_ready && (bus.mdu_reg != '0);
    assign popEn         = !aluWrite && (count != '0);
    assign pushEntry     = '{live: 1'b1, wreg: bus.mdu_reg, data: bus.mdu_data};
    assign headEntry     = entries[headPtr];
    assign bus.busy      = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) fifo (
        .clk      (clk),
        .reset    (reset),
        .pushEn   (pushEn),
        .pushEntry(pushEntry),
        .popEn    (popEn),
        .killEn   (aluWrite),
        .killReg  (bus.alu_reg),
        .entries  (entries),
        .headPtr  (headPtr),
        .count    (count)
    );

    // A killed head still consumes its pop slot; the address/data lines simply hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.RegWrite  <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
        end else if (aluWrite) begin
            bus.RegWrite  <= 1'b1;
            bus.WriteReg  <= bus.alu_reg;
            bus.WriteData <= bus.alu_data;
        end else if (popEn) begin
            bus.RegWrite <= headEntry.live;
            if (headEntry.live) begin
                bus.WriteReg  <= headEntry.wreg;
                bus.WriteData <= headEntry.data;
            end
        end else begin
            bus.RegWrite <= 1'b0;
        end
    end

    assign rdAddr[0] = bus.ReadReg1;
    assign rdAddr[1] = bus.ReadReg2;

    // Queue entries are younger than the output register; scanning oldest to youngest lets the youngest win.
    always_comb begin
        hit = '0;
        for (int p = 0; p < 2; p++) begin
            fwd[p] = '0;
            if (bus.RegWrite && (bus.WriteReg == rdAddr[p])) begin
                hit[p] = 1'b1;
                fwd[p] = bus.WriteData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count) && entries[headPtr + PTR_W'(i)].live &&
                    (entries[headPtr + PTR_W'(i)].wreg == rdAddr[p])) begin
                    hit[p] = 1'b1;
                    fwd[p] = entries[headPtr + PTR_W'(i)].data;
                end
            end
            if (!reset || (rdAddr[p] == '0)) begin
                hit[p] = 1'b0;
                fwd[p] = '0;
            end
        end
    end

    assign bus.fwd_hit1  = hit[0];
    assign bus.fwd_hit2  = hit[1];
    assign bus.fwd_data1 = fwd[0];
    assign bus.fwd_data2 = fwd[1];
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, a reset-mid-traffic sequence, then random traffic
// compared against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;
    import mips_pkg::*;

    localparam int DEPTH = WB_FIFO_DEPTH;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        eRdy;
        logic        eBusy;
        logic        eWe;
        logic [4:0]  eReg;
        logic [31:0] eData;
        logic        eH1;
        logic [31:0] eD1;
        logic        eH2;
        logic [31:0] eD2;
    } vec_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state: pending MDU writes in arrival order, plus the write port register.
    wb_req_t     mq[$];
    logic        mWe   = 1'b0;
    logic [4:0]  mReg  = '0;
    logic [31:0] mData = '0;

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic eRdy, input logic eBusy, input logic eWe, input logic [4:0] eReg,
                                input logic [31:0] eData, input logic eH1, input logic [31:0] eD1,
                                input logic eH2, input logic [31:0] eD2);
        vec_t v;
        v.rst = rst; v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
        v.r1 = r1; v.r2 = r2; v.eRdy = eRdy; v.eBusy = eBusy; v.eWe = eWe; v.eReg = eReg;
        v.eData = eData; v.eH1 = eH1; v.eD1 = eD1; v.eH2 = eH2; v.eD2 = eD2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        bus.alu_valid = v.av;
        bus.alu_reg   = v.ar;
        bus.alu_data  = v.ad;
        bus.mdu_valid = v.mv;
        bus.mdu_reg   = v.mr;
        bus.mdu_data  = v.md;
        bus.ReadReg1  = v.r1;
        bus.ReadReg2  = v.r2;
    endtask

    task automatic checkOutputs(input string tag, input vec_t v);
        chk({tag, ".mdu_ready"}, 32'(bus.mdu_ready), 32'(v.eRdy));
        chk({tag, ".busy"},      32'(bus.busy),      32'(v.eBusy));
        chk({tag, ".RegWrite"},  32'(bus.RegWrite),  32'(v.eWe));
        chk({tag, ".WriteReg"},  32'(bus.WriteReg),  32'(v.eReg));
        chk({tag, ".WriteData"}, bus.WriteData,      v.eData);
        chk({tag, ".fwd_hit1"},  32'(bus.fwd_hit1),  32'(v.eH1));
        chk({tag, ".fwd_data1"}, bus.fwd_data1,      v.eD1);
        chk({tag, ".fwd_hit2"},  32'(bus.fwd_hit2),  32'(v.eH2));
        chk({tag, ".fwd_data2"}, bus.fwd_data2,      v.eD2);
    endtask

    // Youngest live pending write to the register, else the write port if it is writing it.
    task automatic modelFwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (reset && a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!h && mq[i].live && mq[i].wreg == a) begin
                    h = 1'b1;
                    d = mq[i].data;
                end
            end
            if (!h && mWe && mReg == a) begin
                h = 1'b1;
                d = mData;
            end
        end
    endtask

    task automatic modelExpect(inout vec_t v);
        v.eRdy  = reset && (mq.size() < DEPTH);
        v.eBusy = (mq.size() != 0);
        v.eWe   = mWe;
        v.eReg  = mReg;
        v.eData = mData;
        modelFwd(v.r1, v.eH1, v.eD1);
        modelFwd(v.r2, v.eH2, v.eD2);
    endtask

    task automatic modelEdge();
        bit      aluW, push, pop;
        wb_req_t popped;
        if (!reset) begin
            mq.delete();
            mWe = 1'b0; mReg = '0; mData = '0;
            return;
        end
        aluW = bus.alu_valid && bus.alu_reg != 0;
        push = bus.mdu_valid && (mq.size() < DEPTH) && bus.mdu_reg != 0;
        pop  = !aluW && mq.size() > 0;
        if (aluW) foreach (mq[i]) if (mq[i].wreg == bus.alu_reg) mq[i].live = 1'b0;
        if (pop) popped = mq.pop_front();
        if (push) mq.push_back('{live: !(aluW && bus.mdu_reg == bus.alu_reg), wreg: bus.mdu_reg, data: bus.mdu_data});
        if (aluW) begin
            mWe = 1'b1; mReg = bus.alu_reg; mData = bus.alu_data;
        end else if (pop) begin
            mWe = popped.live;
            if (popped.live) begin
                mReg = popped.wreg; mData = popped.data;
            end
        end else begin
            mWe = 1'b0;
        end
    endtask

    task automatic finishCycle();
        modelEdge();
        @(negedge clk);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        v = mk(0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0);
        drive(v); finishCycle();
        drive(v); finishCycle();

        //        rst av ar  ad       mv mr md       r1 r2  rdy bsy we reg data       h1 d1       h2 d2
        tbl.push_back(mk(1, 1,5,'h1234,  0,0,0,      0,0,   1,0,0,0,0,          0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      5,0,   1,0,1,5,'h1234,     1,'h1234, 0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      5,0,   1,0,0,5,'h1234,     0,0,      0,0));
        tbl.push_back(mk(1, 1,10,'h100,  1,3,'hA,    0,0,   1,0,0,5,'h1234,     0,0,      0,0));
        tbl.push_back(mk(1, 1,10,'h100,  1,4,'hB,    0,0,   1,1,1,10,'h100,     0,0,      0,0));
        tbl.push_back(mk(1, 1,10,'h100,  1,5,'hC,    0,0,   1,1,1,10,'h100,     0,0,      0,0));
        tbl.push_back(mk(1, 1,10,'h100,  1,6,'hD,    0,0,   1,1,1,10,'h100,     0,0,      0,0));
        tbl.push_back(mk(1, 1,10,'h100,  1,7,'hE,    6,10,  0,1,1,10,'h100,     1,'hD,    1,'h100));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      3,0,   0,1,1,10,'h100,     1,'hA,    0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      0,0,   1,1,1,3,'hA,        0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      0,0,   1,1,1,4,'hB,        0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      0,0,   1,1,1,5,'hC,        0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      0,0,   1,0,1,6,'hD,        0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      0,0,   1,0,0,6,'hD,        0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       1,7,'h77,   0,0,   1,0,0,6,'hD,        0,0,      0,0));
        tbl.push_back(mk(1, 1,7,'h99,    0,0,0,      7,0,   1,1,0,6,'hD,        1,'h77,   0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      7,0,   1,1,1,7,'h99,       1,'h99,   0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      7,0,   1,0,0,7,'h99,       0,0,      0,0));
        tbl.push_back(mk(1, 1,11,5,      1,8,1,      0,0,   1,0,0,7,'h99,       0,0,      0,0));
        tbl.push_back(mk(1, 1,11,5,      1,8,2,      8,0,   1,1,1,11,5,         1,1,      0,0));
        tbl.push_back(mk(1, 1,11,5,      0,0,0,      8,0,   1,1,1,11,5,         1,2,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      8,0,   1,1,1,11,5,         1,2,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      8,0,   1,1,1,8,1,          1,2,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      8,0,   1,0,1,8,2,          1,2,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      8,0,   1,0,0,8,2,          0,0,      0,0));
        tbl.push_back(mk(1, 1,0,'hEE,    1,0,'hFF,   0,0,   1,0,0,8,2,          0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      0,0,   1,0,0,8,2,          0,0,      0,0));
        tbl.push_back(mk(1, 1,9,'h90,    1,9,'h91,   0,0,   1,0,0,8,2,          0,0,      0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      9,0,   1,1,1,9,'h90,       1,'h90,   0,0));
        tbl.push_back(mk(1, 0,0,0,       0,0,0,      9,0,   1,0,0,9,'h90,       0,0,      0,0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            checkOutputs($sformatf("vec%0d", i), tbl[i]);
            finishCycle();
        end

        // Three entries pending behind a busy ALU, then a one-cycle reset: none of them may ever issue.
        v = mk(1, 1,15,'hF0, 1,12,'h120, 0,0, 1,0,0,9,'h90, 0,0,0,0);
        drive(v); #1; checkOutputs("rst0", v); finishCycle();
        v = mk(1, 1,15,'hF0, 1,13,'h130, 0,0, 1,1,1,15,'hF0, 0,0,0,0);
        drive(v); #1; checkOutputs("rst1", v); finishCycle();
        v = mk(1, 1,15,'hF0, 1,14,'h140, 0,0, 1,1,1,15,'hF0, 0,0,0,0);
        drive(v); #1; checkOutputs("rst2", v); finishCycle();
        v = mk(0, 1,15,'hF0, 1,1,'h1, 12,15, 0,1,1,15,'hF0, 0,0,0,0);
        drive(v); #1; checkOutputs("rst3", v); finishCycle();
        for (int k = 0; k < 5; k++) begin
            v = mk(1, 0,0,0, 0,0,0, 12,13, 1,0,0,0,0, 0,0,0,0);
            drive(v); #1; checkOutputs($sformatf("rstIdle%0d", k), v); finishCycle();
        end

        for (int n = 0; n < 1500; n++) begin
            v.rst = ($urandom_range(0, 49) != 0);
            v.av  = ($urandom_range(0, 99) < 40);
            v.ar  = 5'($urandom_range(0, 7));
            v.ad  = $urandom;
            v.mv  = ($urandom_range(0, 99) < 60);
            v.mr  = 5'($urandom_range(0, 7));
            v.md  = $urandom;
            v.r1  = 5'($urandom_range(0, 7));
            v.r2  = 5'($urandom_range(0, 7));
            drive(v);
            #1;
            modelExpect(v);
            checkOutputs($sformatf("rand%0d", n), v);
            finishCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 DEPTH, 4, MDU writeback queue entries (power of two, >=2).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 alu_valid  in  1  single-cycle ALU writeback request; always accepted, no ready.
REQ-005 alu_reg  in  5  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 mdu_valid  in  1  multi-cycle mul/div writeback request.
REQ-008 mdu_ready  out  1  queue can accept an MDU request this cycle.
REQ-009 mdu_reg  in  5  MDU destination register.
REQ-010 mdu_data  in  32  MDU result.
REQ-011 RegWrite  out  1  register-file write enable, registered.
REQ-012 WriteReg  out  5  register-file write address, registered.
REQ-013 WriteData  out  32  register-file write data, registered.
REQ-014 ReadReg1, ReadReg2  in  5 each  decode-stage read addresses for bypass lookup.
REQ-015 fwd_hit1, fwd_hit2  out  1 each  pending write matches ReadRegN.
REQ-016 fwd_data1, fwd_data2  out  32 each  pending data for ReadRegN; 0 when no hit.
REQ-017 busy  out  1  queue holds at least one entry.

Function
REQ-018 MDU handshake: transfer when mdu_valid && mdu_ready at rising edge; mdu_ready = (count < DEPTH) && reset high, from pre-edge count only (full queue refuses push even when popping).
REQ-019 Accepted MDU request with mdu_reg = 0 is consumed and discarded, never queued.
REQ-020 Each cycle the output register loads exactly one source: ALU request if alu_valid && alu_reg != 0; else queue head if queue non-empty; else RegWrite <= 0.
REQ-021 ALU latency: request at edge N -> RegWrite/WriteReg/WriteData valid after edge N, for one cycle.
REQ-022 MDU latency: minimum 2 cycles (push edge N, earliest pop edge N+1); no queue bypass.
REQ-023 Queue is FIFO; pop advances head, wraps modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-024 Every entry carries a live bit; an ALU write loaded into the output register clears live on all queued entries with the same register.
REQ-025 MDU push same cycle as ALU write to same register: entry enqueued with live = 0 (ALU wins).
REQ-026 Popping a non-live entry drives RegWrite <= 0 that cycle; WriteReg/WriteData hold previous values.
REQ-027 WriteReg = 0 never asserted with RegWrite = 1.
REQ-028 Bypass (combinational): youngest live queue entry matching ReadRegN wins; else output register if RegWrite && WriteReg == ReadRegN; ReadRegN = 0 never hits; same-cycle incoming requests not forwarded.
REQ-029 busy = (count != 0).

Reset
REQ-030 While reset low at an edge: RegWrite, WriteReg, WriteData <= 0; count, head, tail <= 0; all live bits cleared.
REQ-031 While reset low: mdu_ready = 0, requests ignored, fwd_hit1/2 = 0.
REQ-032 Reset mid-operation discards queued entries; no write for them ever issues.

Structure
REQ-033 Package mips_pkg holds REG_W = 5, DATA_W = 32, WB_FIFO_DEPTH = 4, and struct wb_req_t {live, reg, data}.
REQ-034 Queue storage, pointers, count and live-bit kill logic reside in one sub-module wb_fifo; arbitration, output register and bypass stay in wb_arbiter.

Verification
REQ-035 ALU r5 = 0x1234 one cycle, idle MDU -> next cycle RegWrite = 1, WriteReg = 5, WriteData = 0x1234; following cycle RegWrite = 0.
REQ-036 Push MDU r3..r6 (0xA..0xD) while alu_valid held high to r10 -> mdu_ready = 0 after 4th push, busy = 1; drop alu_valid -> r3..r6 written in order on 4 consecutive cycles, then busy = 0, mdu_ready = 1.
REQ-037 Queue MDU r7 = 0x77, next cycle ALU r7 = 0x99 -> r7 written 0x99 once; kill-pop cycle RegWrite = 0; 0x77 never appears with RegWrite = 1.
REQ-038 Queue MDU r8 = 0x1 then r8 = 0x2 (ALU busy), ReadReg1 = 8 -> fwd_hit1 = 1, fwd_data1 = 0x2; ReadReg2 = 0 -> fwd_hit2 = 0.
REQ-039 MDU r0 = 0xFF and ALU r0 = 0xEE -> accepted, no RegWrite, busy stays 0.
REQ-040 Fill 3 entries, assert reset low one cycle -> outputs 0, mdu_ready = 0 during reset, busy = 0 after release, no queued write ever issues.
